// File: rtl/mpc_sched_pkg.sv
// Shared types for the ADMM iteration scheduler: FSM states, stage indices
// and the residual/tolerance word.
package mpc_sched_pkg;

  localparam int SCHED_DATA_WIDTH = 16;
  localparam int SCHED_NUM_STAGES = 5;

  typedef logic [SCHED_DATA_WIDTH-1:0] resid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_CHECK,
    ST_DRAIN,
    ST_FINISH
  } sched_state_t;

  typedef enum logic [2:0] {
    STG_BACKWARD = 3'd0,
    STG_FORWARD  = 3'd1,
    STG_SLACK    = 3'd2,
    STG_DUAL     = 3'd3,
    STG_COST     = 3'd4
  } stage_idx_t;

endpackage

// File: rtl/sched_watchdog.sv
// Phase watchdog: counts enabled cycles since the last clear and flags the
// cycle that reaches the loaded limit.
module sched_watchdog #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_limit;

  // r_count holds cycles already spent, so the limit-th cycle sees limit-1.
  assign w_at_limit = (r_count == i_limit - WIDTH'(1));
  assign o_expired  = i_enable && w_at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/admm_iteration_scheduler.sv
// Sequences the five ADMM stage engines each iteration and decides after
// every iteration whether the solve has converged, hit max_iter or failed.
module admm_iteration_scheduler
  import mpc_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = SCHED_DATA_WIDTH,
  parameter int ITER_WIDTH     = 16,
  parameter int NUM_STAGES     = SCHED_NUM_STAGES,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_solve_start,
  input  logic                  i_abort,
  input  logic [ITER_WIDTH-1:0] i_max_iter,
  input  logic [DATA_WIDTH-1:0] i_tol_pri,
  input  logic [DATA_WIDTH-1:0] i_tol_dual,
  output logic [NUM_STAGES-1:0] o_stage_start,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  input  logic [DATA_WIDTH-1:0] i_pri_res_u,
  input  logic [DATA_WIDTH-1:0] i_pri_res_x,
  input  logic [DATA_WIDTH-1:0] i_dual_res,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_converged,
  output logic                  o_timeout_err,
  output logic [ITER_WIDTH-1:0] o_iter_count,
  output logic [2:0]            o_cur_stage
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t          r_state;
  sched_state_t          w_state_next;
  stage_idx_t            r_stage;
  stage_idx_t            w_stage_next;
  logic [ITER_WIDTH-1:0] r_max_iter;
  logic [DATA_WIDTH-1:0] r_tol_pri;
  logic [DATA_WIDTH-1:0] r_tol_dual;
  logic [ITER_WIDTH-1:0] r_iter;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_converged;
  logic                  r_timeout_err;

  logic w_accept;
  logic w_iter_inc;
  logic w_set_conv;
  logic w_set_timeout;
  logic w_res_ok;
  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;

  assign w_res_ok = (i_pri_res_u <= r_tol_pri) && (i_pri_res_x <= r_tol_pri) &&
                    (i_dual_res <= r_tol_dual);

  // Each handshake phase gets a fresh budget on entry.
  assign w_wd_clear  = (w_state_next != r_state);
  assign w_wd_enable = (r_state == ST_REQ) || (r_state == ST_REL) || (r_state == ST_DRAIN);

  sched_watchdog #(
    .WIDTH(WD_WIDTH)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .i_limit  (WD_WIDTH'(TIMEOUT_CYCLES)),
    .o_expired(w_wd_expired)
  );

  always_comb begin
    w_state_next  = r_state;
    w_stage_next  = r_stage;
    w_accept      = 1'b0;
    w_iter_inc    = 1'b0;
    w_set_conv    = 1'b0;
    w_set_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_solve_start) begin
          w_accept     = 1'b1;
          w_stage_next = STG_BACKWARD;
          w_state_next = (i_max_iter == '0) ? ST_FINISH : ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_abort) begin
          w_state_next = ST_DRAIN;
        end else if (w_wd_expired) begin
          w_set_timeout = 1'b1;
          w_state_next  = ST_FINISH;
        end else if (i_stage_done[r_stage]) begin
          w_state_next = ST_REL;
        end
      end
      ST_REL: begin
        if (i_abort) begin
          w_state_next = ST_DRAIN;
        end else if (w_wd_expired) begin
          w_set_timeout = 1'b1;
          w_state_next  = ST_FINISH;
        end else if (!i_stage_done[r_stage]) begin
          if (r_stage == STG_COST) begin
            w_iter_inc   = 1'b1;
            w_state_next = ST_CHECK;
          end else begin
            w_stage_next = stage_idx_t'(r_stage + 3'd1);
            w_state_next = ST_REQ;
          end
        end
      end
      ST_CHECK: begin
        if (i_abort) begin
          w_state_next = ST_DRAIN;
        end else if (w_res_ok) begin
          w_set_conv   = 1'b1;
          w_state_next = ST_FINISH;
        end else if (r_iter == r_max_iter) begin
          w_state_next = ST_FINISH;
        end else begin
          w_stage_next = STG_BACKWARD;
          w_state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (w_wd_expired) begin
          w_set_timeout = 1'b1;
          w_state_next  = ST_FINISH;
        end else if (i_stage_done == '0) begin
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_stage       <= STG_BACKWARD;
      r_max_iter    <= '0;
      r_tol_pri     <= '0;
      r_tol_dual    <= '0;
      r_iter        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_converged   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_stage <= w_stage_next;
      r_done  <= (r_state == ST_FINISH);
      if (w_accept) begin
        r_max_iter    <= i_max_iter;
        r_tol_pri     <= i_tol_pri;
        r_tol_dual    <= i_tol_dual;
        r_iter        <= '0;
        r_busy        <= 1'b1;
        r_converged   <= 1'b0;
        r_timeout_err <= 1'b0;
      end else begin
        if (r_state == ST_FINISH) begin
          r_busy <= 1'b0;
        end
        if (w_iter_inc && (r_iter != r_max_iter)) begin
          r_iter <= r_iter + ITER_WIDTH'(1);
        end
        if (w_set_conv) begin
          r_converged <= 1'b1;
        end
        if (w_set_timeout) begin
          r_timeout_err <= 1'b1;
        end
      end
    end
  end

  // Start is decoded from the state register so an async reset drops it at once.
  assign o_stage_start = (r_state == ST_REQ) ? (NUM_STAGES'(1) << r_stage) : '0;
  assign o_cur_stage   = ((r_state == ST_IDLE) || (r_state == ST_FINISH)) ? 3'd0 : 3'(r_stage);
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_converged   = r_converged;
  assign o_timeout_err = r_timeout_err;
  assign o_iter_count  = r_iter;

endmodule

// File: tb/tb_admm_iteration_scheduler.sv
// Bench for admm_iteration_scheduler: behavioural stage engines plus an
// iteration-level model of when a solve stops and why.
module tb_admm_iteration_scheduler;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        solve_start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] max_iter = '0;
  logic [15:0] tol_pri = '0;
  logic [15:0] tol_dual = '0;
  logic [4:0]  stage_start;
  logic [4:0]  stage_done = '0;
  logic [15:0] pri_res_u, pri_res_x, dual_res;
  logic        busy, done, converged, timeout_err;
  logic [15:0] iter_count;
  logic [2:0]  cur_stage;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] res_u[16];
  logic [15:0] res_x[16];
  logic [15:0] res_d[16];
  logic [4:0]  stuck = '0;
  int          cnt[5];
  int          start_log[$];
  int          cost_cnt = 0;
  int          onehot_bad = 0;
  int          cur_bad = 0;
  int          s2_cycles = 0;
  logic [4:0]  prev_start = '0;
  logic        prev_busy = 1'b0;
  int          ridx;

  admm_iteration_scheduler #(
    .DATA_WIDTH(16), .ITER_WIDTH(16), .NUM_STAGES(5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_solve_start(solve_start), .i_abort(abort),
    .i_max_iter(max_iter), .i_tol_pri(tol_pri), .i_tol_dual(tol_dual),
    .o_stage_start(stage_start), .i_stage_done(stage_done),
    .i_pri_res_u(pri_res_u), .i_pri_res_x(pri_res_x), .i_dual_res(dual_res),
    .o_busy(busy), .o_done(done), .o_converged(converged),
    .o_timeout_err(timeout_err), .o_iter_count(iter_count), .o_cur_stage(cur_stage)
  );

  always #5 clk = ~clk;

  // Stage engines: done rises 3 cycles after start, falls 1 cycle after start drops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_done <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (stage_start[i]) begin
          cnt[i] <= cnt[i] + 1;
          if (cnt[i] >= 2 && !stuck[i]) stage_done[i] <= 1'b1;
        end else begin
          cnt[i]        <= 0;
          stage_done[i] <= 1'b0;
        end
      end
    end
  end

  // Residuals for iteration k are presented once cost_update of iteration k starts.
  always_comb begin
    ridx = (cost_cnt == 0) ? 0 : ((cost_cnt > 16) ? 15 : cost_cnt - 1);
    pri_res_u = res_u[ridx];
    pri_res_x = res_x[ridx];
    dual_res  = res_d[ridx];
  end

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      start_log.delete();
      cost_cnt  = 0;
      s2_cycles = 0;
    end
    for (int i = 0; i < 5; i++) begin
      if (stage_start[i] && !prev_start[i]) begin
        start_log.push_back(i);
        if (i == 4) cost_cnt++;
      end
    end
    if (!$onehot0(stage_start)) onehot_bad++;
    if (stage_start != 5'd0 && stage_start != (5'd1 << cur_stage)) cur_bad++;
    if (stage_start[2]) s2_cycles++;
    prev_start = stage_start;
    prev_busy  = busy;
  end

  task automatic fill_res(input logic [15:0] v);
    for (int k = 0; k < 16; k++) begin
      res_u[k] = v; res_x[k] = v; res_d[k] = v;
    end
  endtask

  task automatic do_solve(input int maxi, input logic [15:0] tp, input logic [15:0] td,
                          input int poke, output int lat, output bit ok);
    @(negedge clk);
    max_iter = 16'(maxi); tol_pri = tp; tol_dual = td; solve_start = 1'b1;
    @(negedge clk);
    solve_start = 1'b0;
    // scrambling after acceptance checks that the settings were latched
    max_iter = 16'($urandom); tol_pri = 16'($urandom); tol_dual = 16'($urandom);
    lat = 1; ok = 1'b0;
    while (lat < 4000) begin
      if (done) begin ok = 1'b1; break; end
      solve_start = (poke != 0 && lat == poke);
      @(negedge clk);
      lat++;
    end
    solve_start = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL done_wait: no done pulse after %0d cycles, required within 4000", lat);
    end
  endtask

  function automatic int log_order_bad();
    int bad = 0;
    for (int j = 0; j < start_log.size(); j++)
      if (start_log[j] != j % 5) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    fill_res(16'h0100);
    repeat (2) @(negedge clk);
    n_vec++; if ({stage_start, busy, done, converged, timeout_err} !== 9'd0) begin n_err++;
      $display("FAIL reset_flags: got start=%b busy=%b done=%b conv=%b to=%b, required all 0",
               stage_start, busy, done, converged, timeout_err); end
    n_vec++; if (iter_count !== 16'd0 || cur_stage !== 3'd0) begin n_err++;
      $display("FAIL reset_counts: got iter=%0d cur=%0d, required 0/0", iter_count, cur_stage); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || stage_start !== 5'd0) begin n_err++;
      $display("FAIL reset_idle: got busy=%b start=%b, required 0/0", busy, stage_start); end
    $display("reset: outputs checked");
  endtask

  task automatic test_converge();
    int lat; bit ok;
    fill_res(16'h0100);
    res_u[2] = 16'h0008; res_x[2] = 16'h0008; res_d[2] = 16'h0008;
    do_solve(10, 16'h0010, 16'h0010, 0, lat, ok);
    n_vec++; if (converged !== 1'b1 || iter_count !== 16'd3) begin n_err++;
      $display("FAIL conv_result: got conv=%b iter=%0d, required 1/3", converged, iter_count); end
    n_vec++; if (start_log.size() != 15 || log_order_bad() != 0) begin n_err++;
      $display("FAIL conv_order: got %0d starts with %0d out of order, required 15/0",
               start_log.size(), log_order_bad()); end
    n_vec++; if (onehot_bad != 0 || cur_bad != 0) begin n_err++;
      $display("FAIL conv_onehot: got %0d overlap cycles, %0d cur_stage errors, required 0/0",
               onehot_bad, cur_bad); end
    n_vec++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_err++;
      $display("FAIL conv_flags: got busy=%b to=%b, required 0/0", busy, timeout_err); end
    $display("converge: iters=%0d conv=%b latency=%0d", iter_count, converged, lat);
  endtask

  task automatic test_reset_mid();
    int k; int lat; bit ok;
    fill_res(16'h0100);
    @(negedge clk);
    max_iter = 16'd10; tol_pri = 16'h0010; tol_dual = 16'h0010; solve_start = 1'b1;
    @(negedge clk);
    solve_start = 1'b0;
    k = 0;
    while (k < 1000 && !(iter_count == 16'd1 && stage_start[3])) begin @(negedge clk); k++; end
    n_vec++; if (k >= 1000) begin n_err++;
      $display("FAIL rstmid_reach: stage 3 of iteration 2 not seen, required within 1000 cycles"); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({stage_start, busy, done, converged} !== 8'd0 || iter_count !== 16'd0) begin n_err++;
      $display("FAIL rstmid_clear: got start=%b busy=%b done=%b conv=%b iter=%0d, required all 0",
               stage_start, busy, done, converged, iter_count); end
    @(negedge clk);
    rst = 1'b0;
    fill_res(16'h0008);
    do_solve(5, 16'h0010, 16'h0010, 0, lat, ok);
    n_vec++; if (converged !== 1'b1 || iter_count !== 16'd1 || start_log.size() != 5) begin n_err++;
      $display("FAIL rstmid_after: got conv=%b iter=%0d starts=%0d, required 1/1/5",
               converged, iter_count, start_log.size()); end
    $display("reset_mid: fresh solve iters=%0d conv=%b", iter_count, converged);
  endtask

  task automatic test_max_iter();
    int lat; bit ok;
    fill_res(16'h0100);
    do_solve(4, 16'h0010, 16'h0010, 30, lat, ok);
    n_vec++; if (converged !== 1'b0 || iter_count !== 16'd4 || timeout_err !== 1'b0) begin n_err++;
      $display("FAIL maxiter_result: got conv=%b iter=%0d to=%b, required 0/4/0",
               converged, iter_count, timeout_err); end
    n_vec++; if (start_log.size() != 20 || log_order_bad() != 0) begin n_err++;
      $display("FAIL maxiter_order: got %0d starts, %0d out of order, required 20/0",
               start_log.size(), log_order_bad()); end
    $display("max_iter: iters=%0d conv=%b latency=%0d", iter_count, converged, lat);
  endtask

  task automatic test_zero_iter();
    int lat; bit ok;
    do_solve(0, 16'h0010, 16'h0010, 0, lat, ok);
    n_vec++; if (lat != 2) begin n_err++;
      $display("FAIL zero_latency: got done %0d cycles after start, required 2", lat); end
    n_vec++; if (start_log.size() != 0 || iter_count !== 16'd0 || converged !== 1'b0) begin n_err++;
      $display("FAIL zero_result: got starts=%0d iter=%0d conv=%b, required 0/0/0",
               start_log.size(), iter_count, converged); end
    $display("zero_iter: latency=%0d", lat);
  endtask

  task automatic test_random();
    int lat; bit ok; int maxi; int exp_it; bit exp_conv;
    logic [15:0] tp, td;
    for (int t = 0; t < 20; t++) begin
      maxi = $urandom_range(1, 6);
      tp = 16'($urandom_range(16'h0040, 16'h0200));
      td = 16'($urandom_range(16'h0040, 16'h0200));
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 9) < 3) begin
          res_u[k] = 16'($urandom_range(0, int'(tp))); res_x[k] = tp;
          res_d[k] = 16'($urandom_range(0, int'(td)));
        end else begin
          res_u[k] = ($urandom_range(0, 3) == 0) ? tp : 16'($urandom_range(0, 16'h0300));
          res_x[k] = 16'($urandom_range(0, 16'h0300));
          res_d[k] = ($urandom_range(0, 3) == 0) ? td + 16'd1 : 16'($urandom_range(0, 16'h0300));
        end
      end
      exp_it = 0; exp_conv = 1'b0;
      for (int k = 1; k <= maxi; k++) begin
        exp_it = k;
        if (res_u[k-1] <= tp && res_x[k-1] <= tp && res_d[k-1] <= td) begin
          exp_conv = 1'b1; break;
        end
      end
      do_solve(maxi, tp, td, 0, lat, ok);
      n_vec++; if (iter_count !== 16'(exp_it) || converged !== exp_conv) begin n_err++;
        $display("FAIL rand_result[%0d]: got iter=%0d conv=%b, required %0d/%b",
                 t, iter_count, converged, exp_it, exp_conv); end
      n_vec++; if (start_log.size() != 5 * exp_it || log_order_bad() != 0 || timeout_err !== 1'b0) begin
        n_err++;
        $display("FAIL rand_seq[%0d]: got %0d starts, %0d misordered, to=%b, required %0d/0/0",
                 t, start_log.size(), log_order_bad(), timeout_err, 5 * exp_it); end
      $display("random %0d: max=%0d tp=%h td=%h iters=%0d conv=%b", t, maxi, tp, td, iter_count, converged);
    end
    n_vec++; if (onehot_bad != 0 || cur_bad != 0) begin n_err++;
      $display("FAIL rand_onehot: got %0d overlaps, %0d cur_stage errors, required 0/0", onehot_bad, cur_bad); end
  endtask

  task automatic test_timeout();
    int lat; bit ok;
    fill_res(16'h0100);
    stuck = 5'b00100;
    do_solve(3, 16'h0010, 16'h0010, 0, lat, ok);
    n_vec++; if (timeout_err !== 1'b1 || converged !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL to_flags: got to=%b conv=%b busy=%b, required 1/0/0", timeout_err, converged, busy); end
    n_vec++; if (s2_cycles != TO || stage_start !== 5'd0 || iter_count !== 16'd0) begin n_err++;
      $display("FAIL to_window: got stage2 start %0d cycles, start=%b iter=%0d, required %0d/0/0",
               s2_cycles, stage_start, iter_count, TO); end
    stuck = '0;
    fill_res(16'h0008);
    do_solve(2, 16'h0010, 16'h0010, 0, lat, ok);
    n_vec++; if (timeout_err !== 1'b0 || converged !== 1'b1 || iter_count !== 16'd1) begin n_err++;
      $display("FAIL to_clear: got to=%b conv=%b iter=%0d, required 0/1/1", timeout_err, converged, iter_count); end
    $display("timeout: stage2 window=%0d cycles", s2_cycles);
  endtask

  task automatic test_abort();
    int k;
    fill_res(16'h0100);
    @(negedge clk);
    max_iter = 16'd10; tol_pri = 16'h0010; tol_dual = 16'h0010; solve_start = 1'b1;
    @(negedge clk);
    solve_start = 1'b0;
    k = 0;
    while (k < 300 && !(stage_start[1] && stage_done[1])) begin @(negedge clk); k++; end
    n_vec++; if (k >= 300) begin n_err++;
      $display("FAIL abort_reach: stage 1 done not seen, required within 300 cycles"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++; if (stage_start !== 5'd0 || stage_done[1] !== 1'b1 || busy !== 1'b1) begin n_err++;
      $display("FAIL abort_drain: got start=%b done1=%b busy=%b, required 0/1/1",
               stage_start, stage_done[1], busy); end
    k = 0;
    while (k < 100 && !done) begin @(negedge clk); k++; end
    n_vec++; if (k >= 100 || converged !== 1'b0 || iter_count !== 16'd0 || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL abort_result: got wait=%0d conv=%b iter=%0d to=%b, required <100/0/0/0",
               k, converged, iter_count, timeout_err); end
    n_vec++; if (start_log.size() != 2 || stage_done !== 5'd0) begin n_err++;
      $display("FAIL abort_stages: got %0d starts, stage_done=%b, required 2/0", start_log.size(), stage_done); end
    $display("abort: drained in %0d cycles", k);
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    max_iter = 16'd0; solve_start = 1'b1;
    k = 0;
    while (k < 10 && !done) begin @(negedge clk); k++; end
    n_vec++; if (k >= 10 || busy !== 1'b0) begin n_err++;
      $display("FAIL b2b_first: got wait=%0d busy=%b, required <10/0", k, busy); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++;
      $display("FAIL b2b_retrigger: got busy=%b done=%b, required 1/0", busy, done); end
    solve_start = 1'b0;
    @(negedge clk);
    n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL b2b_second: got done=%b busy=%b, required 1/0", done, busy); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL b2b_idle: got done=%b busy=%b, required 0/0", done, busy); end
    $display("back_to_back: retrigger checked");
  endtask

  initial begin
    test_reset();
    test_converge();
    test_reset_mid();
    test_max_iter();
    test_zero_iter();
    test_random();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/admm_iteration_scheduler.md
Name: admm_iteration_scheduler

Overview:
Top-level sequencer for one MPC solve. It runs the ADMM stage engines in a fixed order each iteration: backward_pass, forward_pass, slack_update, dual_update, then cost_update. After each iteration it checks the residuals from cost_update and the dual-residual unit against tolerances, and loops until converged, max_iter, abort or watchdog timeout. It owns all stage start/done handshakes; no stage engine is started by anything else.

Parameters:
DATA_WIDTH, 16, residual/tolerance width (Q8.8, compared unsigned)
ITER_WIDTH, 16, iteration counter width
NUM_STAGES, 5, number of stage engines (fixed order, index 0..4)
TIMEOUT_CYCLES, 65535, max cycles in any single handshake phase before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
solve_start  in  1  level; sampled only in IDLE
abort  in  1  level; terminates solve
max_iter  in  ITER_WIDTH  iteration limit, sampled at solve_start
tol_pri  in  DATA_WIDTH  primal tolerance, sampled at solve_start
tol_dual  in  DATA_WIDTH  dual tolerance, sampled at solve_start
stage_start  out  NUM_STAGES  level start per engine (bit0=backward … bit4=cost_update)
stage_done  in  NUM_STAGES  level done per engine
pri_res_u  in  DATA_WIDTH  from cost_update
pri_res_x  in  DATA_WIDTH  from cost_update
dual_res  in  DATA_WIDTH  from dual residual unit
busy  out  1  high from accepted start until FINISH
done  out  1  one-cycle pulse at end of solve
converged  out  1  result flag, held until next accepted start
timeout_err  out  1  sticky, cleared at next accepted start
iter_count  out  ITER_WIDTH  completed iterations, held after solve
cur_stage  out  3  index of active stage (debug), 0 when idle

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- States: IDLE, REQ, REL, CHECK, DRAIN, FINISH.
- IDLE: on solve_start=1, latch max_iter/tol_*; clear converged, timeout_err and iter_count; set busy. If latched max_iter==0, go to FINISH. Otherwise go to REQ with stage 0.
- REQ: stage_start[s]=1 and no other bit set. On sampling stage_done[s]=1, deassert start on the next cycle and go to REL.
- REL: wait for stage_done[s]=0. Then, if s<4, set s+1 and go to REQ, so the next start asserts the following cycle. If s==4, increment iter_count and go to CHECK.
- Throughput: one idle cycle between handshakes. A stage with 1-cycle internal latency costs 4 cycles of scheduler overhead.
- CHECK (1 cycle): converged_next = pri_res_u<=tol_pri and pri_res_x<=tol_pri and dual_res<=tol_dual, all compared unsigned.
  - If converged_next, set converged=1 and go to FINISH.
  - Else if iter_count==max_iter, go to FINISH with converged=0.
  - Else go to REQ with s=0.
- Residuals are sampled only in CHECK; they are stable there because cost_update has completed and dropped done.
- Watchdog: counter cleared on every REQ/REL entry, counting each cycle in REQ/REL. On reaching TIMEOUT_CYCLES: set timeout_err, drop all stage_start, and go straight to FINISH (no drain). converged=0.
- Abort: abort=1 in REQ/REL/CHECK drops all stage_start on the next cycle and enters DRAIN. DRAIN waits until stage_done==0 (all bits), subject to the same watchdog, then goes to FINISH with converged=0. Abort in IDLE is ignored. Abort has priority over a simultaneous stage_done rise.
- FINISH (1 cycle): done=1, busy=0, then IDLE. solve_start held high re-triggers a new solve on the following cycle.
- solve_start while busy is ignored.
- iter_count saturates at max_iter; it never wraps.
- Async reset mid-solve: every stage_start drops immediately, all outputs return to 0. Stage engines rely on a shared rst.

Decomposition:
- Package mpc_sched_pkg: sched_state_t enum, stage_idx_t enum (STG_BACKWARD … STG_COST), NUM_STAGES, residual/tolerance typedef of DATA_WIDTH.
- Sub-module sched_watchdog: loadable counter with clear/enable and an expired output. Reused by other controllers.

Test Plan:
- Bench model: each stage raises done 3 cycles after start and drops it 1 cycle after start falls. tol_pri=tol_dual=0x0010, max_iter=10, residuals 0x0100 for iterations 1-2 and 0x0008 on iteration 3 -> done with converged=1, iter_count=3. Stage starts are observed in order 0..4 three times, one-hot, never overlapping.
- Residuals always 0x0100, max_iter=4 -> done after 4 iterations, converged=0, iter_count=4, timeout_err=0.
- max_iter=0 -> done pulse 2 cycles after solve_start, no stage_start ever asserted, iter_count=0.
- TIMEOUT_CYCLES=50, stage 2 never raises done -> timeout_err=1 at cycle 50 of that REQ, stage_start=0, done pulse, busy=0; next solve_start clears timeout_err.
- abort during stage 1 REQ with done already high -> start drops, DRAIN until done falls, done pulse with converged=0. A second solve_start during busy is ignored (iter_count unaffected).
- rst asserted mid-stage 3 -> stage_start, busy, done, converged and iter_count read 0 in the same cycle. A fresh solve then completes normally.
